// File: rtl/flow_pkg.sv
// -----------------------------------------------------------------------------
// flow_pkg
// Shared definitions for the flow-ID responder:
//   TUPLE_WIDTH  - width of the arbiter's 4-tuple search key
//   ID_WIDTH     - width of the flow ID returned to the arbiter
//   NO_ID        - ID value meaning "no flow ID" (flow IDs are index+1)
//   flow_tuple_t - field view of the 4-tuple key
// -----------------------------------------------------------------------------
package flow_pkg;

  localparam int TUPLE_WIDTH = 96;
  localparam int ID_WIDTH    = 16;

  localparam logic [ID_WIDTH-1:0] NO_ID = 16'h0000;

  // Field layout of the search key as issued by the arbiter.
  typedef struct packed {
    logic [31:0] src_ip;    // [95:64]
    logic [31:0] dst_ip;    // [63:32]
    logic [15:0] src_port;  // [31:16]
    logic [15:0] dst_port;  // [15:0]
  } flow_tuple_t;

endpackage

// File: rtl/flow_prio_enc.sv
// -----------------------------------------------------------------------------
// flow_prio_enc
// Lowest-set-bit priority encoder.
// Ports:
//   req_i   [WIDTH]  request vector
//   found_o          at least one bit of req_i is set
//   index_o [IDX_W]  index of the lowest set bit (0 when nothing is set)
// -----------------------------------------------------------------------------
module flow_prio_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             found_o,
  output logic [IDX_W-1:0] index_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    found_o = |req_i;
    index_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      index_o = req_i[i] ? IDX_W'(i) : index_o;
    end
  end

endmodule

// File: rtl/flow_id_responder.sv
// -----------------------------------------------------------------------------
// flow_id_responder
// Answers the arbiter's flow-ID search requests. A 4-tuple key is matched
// against a register-based flow table; on a hit the entry's ID is returned,
// on a miss the key is written into the lowest free entry and its new ID is
// returned. Flow ID = entry index + 1, 0 means "no ID".
//
// Two-stage pipeline, one request per cycle, no backpressure:
//   edge k   : request captured into S1
//   cycle    : S1 key compared against all valid entries (hit / free encoders)
//   edge k+1 : table insert and result registers update
//
// Ports:
//   clk                    system clock (rising edge)
//   reset                  asynchronous active-low reset
//   in_valid_tuple4search  one-cycle search strobe
//   in_tuple4search        search key, qualified by the strobe
//   in_clear               one-cycle strobe, invalidates the whole table
//   out_valid_id           one-cycle result strobe
//   out_id                 flow ID (index+1), 0 when no ID / not valid
//   out_hit                key was already present
//   out_new                key was inserted by this request
//   out_full               miss with no free entry
//   out_flow_count         registered count of valid entries
//
// Optional build macro FLOW_AGE_EN: per-entry idle counters expire entries
// that have not been hit or inserted for AGE_TIMEOUT cycles.
// -----------------------------------------------------------------------------
module flow_id_responder #(
  parameter int TABLE_DEPTH = 16,
  parameter int TUPLE_WIDTH = flow_pkg::TUPLE_WIDTH,
  parameter int ID_WIDTH    = flow_pkg::ID_WIDTH,
  parameter int AGE_TIMEOUT = 1000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid_tuple4search,
  input  logic [TUPLE_WIDTH-1:0]             in_tuple4search,
  input  logic                               in_clear,
  output logic                               out_valid_id,
  output logic [ID_WIDTH-1:0]                out_id,
  output logic                               out_hit,
  output logic                               out_new,
  output logic                               out_full,
  output logic [$clog2(TABLE_DEPTH+1)-1:0]   out_flow_count
);

  import flow_pkg::*;

  localparam int IDX_W = $clog2(TABLE_DEPTH);
  localparam int CNT_W = $clog2(TABLE_DEPTH + 1);

  localparam logic [ID_WIDTH-1:0] ID_NONE = ID_WIDTH'(NO_ID);
  localparam logic [ID_WIDTH-1:0] ID_ONE  = {{(ID_WIDTH-1){1'b0}}, 1'b1};

  // Population count of the valid vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [TABLE_DEPTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Stage 1 request
  logic                   s1_valid_q;
  logic [TUPLE_WIDTH-1:0] s1_key_q;

  // Flow table
  logic [TUPLE_WIDTH-1:0] key_q [TABLE_DEPTH];
  logic [TABLE_DEPTH-1:0] valid_q, valid_d;
  logic [TABLE_DEPTH-1:0] match_s;
  logic [TABLE_DEPTH-1:0] expire_s;

  // Encoder results
  logic             hit_found_s, free_found_s;
  logic [IDX_W-1:0] hit_idx_s, free_idx_s;
  logic             insert_s;

  // Result registers
  logic                out_valid_q, out_hit_q, out_new_q, out_full_q;
  logic                hit_d, new_d, full_d;
  logic [ID_WIDTH-1:0] out_id_q, id_d;
  logic [CNT_W-1:0]    count_q;

  // Capture the incoming request into stage 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_key_q   <= '0;
    end else begin
      s1_valid_q <= in_valid_tuple4search;
      s1_key_q   <= in_tuple4search;
    end
  end

  // Parallel compare of the stage-1 key against every valid entry.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      match_s[i] = valid_q[i] && (key_q[i] == s1_key_q);
    end
  end

  flow_prio_enc #(.WIDTH(TABLE_DEPTH), .IDX_W(IDX_W)) u_hit_enc (
    .req_i   (match_s),
    .found_o (hit_found_s),
    .index_o (hit_idx_s)
  );

  flow_prio_enc #(.WIDTH(TABLE_DEPTH), .IDX_W(IDX_W)) u_free_enc (
    .req_i   (~valid_q),
    .found_o (free_found_s),
    .index_o (free_idx_s)
  );

  // A clear on this edge wins over any insert.
  assign insert_s = s1_valid_q && !in_clear && !hit_found_s && free_found_s;

`ifdef FLOW_AGE_EN
  localparam int AGE_W = $clog2(AGE_TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};

  logic [AGE_W-1:0]       age_q [TABLE_DEPTH];
  logic [AGE_W-1:0]       age_d [TABLE_DEPTH];
  logic [TABLE_DEPTH-1:0] touch_s;

  // Entries touched by this cycle's hit or insert; a touch also vetoes expiry.
  always_comb begin
    touch_s  = '0;
    expire_s = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      touch_s[i]  = (s1_valid_q && hit_found_s && (hit_idx_s == IDX_W'(i))) ||
                    (insert_s && (free_idx_s == IDX_W'(i)));
      expire_s[i] = valid_q[i] && (age_q[i] == AGE_MAX) && !touch_s[i];
    end
  end

  // Idle counters: clear on touch, count while valid, hold at the timeout.
  always_comb begin
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (touch_s[i]) begin
        age_d[i] = '0;
      end else if (!valid_q[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + AGE_ONE;
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  // Idle counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign expire_s = '0;
`endif

  // Next valid vector: clear beats insert; expiry only drops entries.
  always_comb begin
    valid_d = valid_q & ~expire_s;
    if (in_clear) begin
      valid_d = '0;
    end else if (insert_s) begin
      valid_d[free_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q & ~expire_s;
    end
  end

  // Result of the request currently in stage 1.
  always_comb begin
    id_d   = ID_NONE;
    hit_d  = 1'b0;
    new_d  = 1'b0;
    full_d = 1'b0;
    if (!s1_valid_q || in_clear) begin
      id_d = ID_NONE;
    end else if (hit_found_s) begin
      id_d  = ID_WIDTH'(hit_idx_s) + ID_ONE;
      hit_d = 1'b1;
    end else if (free_found_s) begin
      id_d  = ID_WIDTH'(free_idx_s) + ID_ONE;
      new_d = 1'b1;
    end else begin
      full_d = 1'b1;
    end
  end

  // Valid bits and the lagging flow count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= popcount(valid_q);
    end
  end

  // Key storage carries no reset; entries are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (insert_s) begin
      key_q[free_idx_s] <= s1_key_q;
    end
  end

  // Registered result interface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_id_q    <= ID_NONE;
      out_hit_q   <= 1'b0;
      out_new_q   <= 1'b0;
      out_full_q  <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_id_q    <= id_d;
      out_hit_q   <= hit_d;
      out_new_q   <= new_d;
      out_full_q  <= full_d;
    end
  end

  assign out_valid_id   = out_valid_q;
  assign out_id         = out_id_q;
  assign out_hit        = out_hit_q;
  assign out_new        = out_new_q;
  assign out_full       = out_full_q;
  assign out_flow_count = count_q;

endmodule

// File: tb/tb_flow_id_responder.sv
// -----------------------------------------------------------------------------
// tb_flow_id_responder
// Self-checking bench for flow_id_responder. Inputs are driven on the falling
// edge and outputs are observed on the falling edge. A behavioural model
// resolves each request in issue order against an array of keys; its result
// is expected on the outputs two cycles after the strobe.
// -----------------------------------------------------------------------------
module tb_flow_id_responder;

  localparam int DEPTH = 16;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        in_valid = 1'b0;
  logic [95:0] in_key   = '0;
  logic        in_clear = 1'b0;

  logic        out_valid_id;
  logic [15:0] out_id;
  logic        out_hit, out_new, out_full;
  logic [4:0]  out_flow_count;

  int tests_run    = 0;
  int tests_failed = 0;

  flow_id_responder #(
    .TABLE_DEPTH (16),
    .TUPLE_WIDTH (96),
    .ID_WIDTH    (16),
    .AGE_TIMEOUT (20)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_valid_tuple4search (in_valid),
    .in_tuple4search       (in_key),
    .in_clear              (in_clear),
    .out_valid_id          (out_valid_id),
    .out_id                (out_id),
    .out_hit               (out_hit),
    .out_new               (out_new),
    .out_full              (out_full),
    .out_flow_count        (out_flow_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [95:0] m_key [DEPTH];
  bit          m_valid [DEPTH];
  bit          pend_v;
  logic [95:0] pend_key;
  bit          e_valid, e_hit, e_new, e_full;
  int          e_id, e_count;

  function automatic int m_popcount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    pend_v = 1'b0; e_valid = 1'b0; e_hit = 1'b0; e_new = 1'b0; e_full = 1'b0;
    e_id = 0; e_count = 0;
  endtask

  // One cycle: resolve the request issued last cycle, then queue this one.
  task automatic model_cycle(input bit r, input logic [95:0] k, input bit c);
    int hit_at = -1;
    int free_at = -1;
    e_count = m_popcount();
    e_valid = pend_v; e_hit = 1'b0; e_new = 1'b0; e_full = 1'b0; e_id = 0;
    if (c) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end else if (pend_v) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (m_valid[i] && m_key[i] == pend_key) hit_at = i;
        if (!m_valid[i]) free_at = i;
      end
      if (hit_at >= 0) begin
        e_hit = 1'b1; e_id = hit_at + 1;
      end else if (free_at >= 0) begin
        e_new = 1'b1; e_id = free_at + 1;
        m_valid[free_at] = 1'b1; m_key[free_at] = pend_key;
      end else begin
        e_full = 1'b1;
      end
    end
    pend_v = r; pend_key = k;
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model.
  task automatic drive(input bit r, input logic [95:0] k, input bit c);
    in_valid = r; in_key = k; in_clear = c;
    model_cycle(r, k, c);
    @(negedge clk);
  endtask

  function automatic logic [95:0] fill_key(input int i);
    return {32'hCC00_0000 + 32'(i), 32'h0A0A_0A0A, 16'd5000, 16'(i)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid_id, out_hit, out_new, out_full} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {out_valid_id, out_hit, out_new, out_full});
    end
    tests_run++;
    if (out_id !== 16'd0 || out_flow_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_id_count: got id=%0d count=%0d expected 0/0", out_id, out_flow_count);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_insert_hit();
    drive(1'b1, 96'haaaa1111, 1'b0);
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_id === 16'd1 && out_new === 1'b1 && out_hit === 1'b0)) begin
      tests_failed++;
      $display("FAIL first_insert: got v=%b id=%0d new=%b hit=%b expected 1/1/1/0", out_valid_id, out_id, out_new, out_hit);
    end
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (out_valid_id !== 1'b0 || out_flow_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL first_count: got v=%b count=%0d expected 0/1", out_valid_id, out_flow_count);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 96'haaaa1111, 1'b0);
    drive(1'b1, 96'haaaa2222, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_id === 16'd1 && out_hit === 1'b1 && out_new === 1'b0)) begin
      tests_failed++;
      $display("FAIL b2b_hit: got v=%b id=%0d hit=%b new=%b expected 1/1/1/0", out_valid_id, out_id, out_hit, out_new);
    end
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_id === 16'd2 && out_new === 1'b1 && out_hit === 1'b0)) begin
      tests_failed++;
      $display("FAIL b2b_new: got v=%b id=%0d new=%b hit=%b expected 1/2/1/0", out_valid_id, out_id, out_new, out_hit);
    end
  endtask

  task automatic test_same_new_key();
    drive(1'b1, 96'hbbbb0001, 1'b0);
    drive(1'b1, 96'hbbbb0001, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_id === 16'd3 && out_new === 1'b1)) begin
      tests_failed++;
      $display("FAIL dup_first: got v=%b id=%0d new=%b expected 1/3/1", out_valid_id, out_id, out_new);
    end
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_id === 16'd3 && out_hit === 1'b1 && out_new === 1'b0)) begin
      tests_failed++;
      $display("FAIL dup_second: got v=%b id=%0d hit=%b new=%b expected 1/3/1/0", out_valid_id, out_id, out_hit, out_new);
    end
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (out_flow_count !== 5'd3) begin
      tests_failed++;
      $display("FAIL dup_count: got %0d expected 3", out_flow_count);
    end
  endtask

  task automatic test_full_and_clear();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i <= DEPTH; i++) begin
      drive(1'b1, fill_key(i), 1'b0);
      if (i >= 1) begin
        tests_run++;
        if (!(out_valid_id === 1'b1 && out_new === 1'b1 && out_id === 16'(i))) begin
          tests_failed++;
          $display("FAIL fill_%0d: got v=%b new=%b id=%0d expected 1/1/%0d", i, out_valid_id, out_new, out_id, i);
        end
      end
    end
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_full === 1'b1 && out_id === 16'd0 && out_new === 1'b0 && out_hit === 1'b0)) begin
      tests_failed++;
      $display("FAIL full: got v=%b full=%b id=%0d new=%b hit=%b expected 1/1/0/0/0", out_valid_id, out_full, out_id, out_new, out_hit);
    end
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (out_flow_count !== 5'd16) begin
      tests_failed++;
      $display("FAIL full_count: got %0d expected 16", out_flow_count);
    end
    drive(1'b0, '0, 1'b1);
    drive(1'b1, fill_key(DEPTH), 1'b0);
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_new === 1'b1 && out_id === 16'd1)) begin
      tests_failed++;
      $display("FAIL after_clear: got v=%b new=%b id=%0d expected 1/1/1", out_valid_id, out_new, out_id);
    end
  endtask

  task automatic test_clear_in_flight();
    drive(1'b1, 96'hdddd0001, 1'b0);
    drive(1'b0, '0, 1'b1);
    tests_run++;
    if ({out_valid_id, out_hit, out_new, out_full} !== 4'b1000 || out_id !== 16'd0) begin
      tests_failed++;
      $display("FAIL clear_inflight: got vhnf=%b id=%0d expected 1000/0", {out_valid_id, out_hit, out_new, out_full}, out_id);
    end
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (out_flow_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL clear_count: got %0d expected 0", out_flow_count);
    end
  endtask

  task automatic test_reset_mid_request();
    drive(1'b1, 96'haaaa1111, 1'b0);
    drive(1'b1, 96'heeee0001, 1'b0);
    reset = 1'b0; in_valid = 1'b0; in_clear = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0);
      tests_run++;
      if (out_valid_id !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_lost_%0d: got v=%b expected 0", i, out_valid_id);
      end
    end
    tests_run++;
    if (out_flow_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d expected 0", out_flow_count);
    end
    drive(1'b1, 96'heeee0001, 1'b0);
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_new === 1'b1 && out_id === 16'd1)) begin
      tests_failed++;
      $display("FAIL reset_next: got v=%b new=%b id=%0d expected 1/1/1", out_valid_id, out_new, out_id);
    end
  endtask

  task automatic test_random();
    logic [24:0] obs, exp;
    int idx;
    bit r, c;
    drive(1'b0, '0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) < 70);
      c   = ($urandom_range(0, 99) < 2);
      idx = $urandom_range(0, 23);
      drive(r, {32'hC0A8_0000 + 32'(idx), 32'h0A00_0001, 16'd1000 + 16'(idx), 16'd80}, c);
      obs = {out_valid_id, out_hit, out_new, out_full, out_id, out_flow_count};
      exp = {e_valid, e_hit, e_new, e_full, 16'(e_id), 5'(e_count)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL random_%0d: got vhnf=%b id=%0d cnt=%0d expected vhnf=%b id=%0d cnt=%0d",
                 n, obs[24:21], obs[20:5], obs[4:0], exp[24:21], exp[20:5], exp[4:0]);
      end
    end
  endtask

`ifdef FLOW_AGE_EN
  task automatic test_aging();
    drive(1'b0, '0, 1'b1);
    drive(1'b1, 96'hf00d0001, 1'b0);
    repeat (25) drive(1'b0, '0, 1'b0);
    drive(1'b1, 96'hf00d0001, 1'b0);
    drive(1'b0, '0, 1'b0);
    tests_run++;
    if (!(out_valid_id === 1'b1 && out_new === 1'b1 && out_id === 16'd1)) begin
      tests_failed++;
      $display("FAIL age_expire: got v=%b new=%b id=%0d expected 1/1/1", out_valid_id, out_new, out_id);
    end
    for (int k = 0; k < 5; k++) begin
      repeat (8) drive(1'b0, '0, 1'b0);
      drive(1'b1, 96'hf00d0001, 1'b0);
      drive(1'b0, '0, 1'b0);
      tests_run++;
      if (!(out_valid_id === 1'b1 && out_hit === 1'b1 && out_id === 16'd1)) begin
        tests_failed++;
        $display("FAIL age_refresh_%0d: got v=%b hit=%b id=%0d expected 1/1/1", k, out_valid_id, out_hit, out_id);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_insert_hit();
    test_back_to_back();
    test_same_new_key();
    test_full_and_clear();
    test_clear_in_flight();
    test_reset_mid_request();
`ifdef FLOW_AGE_EN
    test_aging();
`else
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
